node_input_arbiter: RTL

NODE_INPUT_ARBITER -- requirements
Module: node_input_arbiter

---
 rtl/node_pkg.sv | 33 +++
 rtl/node_fifo.sv | 73 +++++++
 rtl/node_input_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/node_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// node_pkg -- port codes and instruction field layout shared by the node arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package node_pkg;

  localparam int NUM_PORTS        = 3;
  localparam int NODE_IP_BITWIDTH = 3;
  localparam int INSTR_W          = 32;

  localparam logic [1:0] PORT_LINK0 = 2'b00;
  localparam logic [1:0] PORT_LINK1 = 2'b01;
  localparam logic [1:0] PORT_LOCAL = 2'b10;

  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 29;
  localparam int ORIG_MSB = 28;
  localparam int ORIG_LSB = 26;

  typedef struct packed {
    logic [NODE_IP_BITWIDTH-1:0] dest;
    logic [NODE_IP_BITWIDTH-1:0] orig;
    logic [25:0]                 payload;
  } instr_t;

  // Round-robin successor over the three port codes, wrapping local back to link0
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == PORT_LOCAL) ? PORT_LINK0 : p + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/node_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// node_fifo -- per-port FIFO with valid/ready push and pop/empty/full read side
// Rev 1.0
// ----------------------------------------------------------------------------
module node_fifo
  import node_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INSTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_en;
  logic             pop_en;

  // Ready comes only from the registered count, so a full FIFO refuses even when popped
  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign push_ready = !full && !reset;
  assign push_en    = push_valid && push_ready;
  assign pop_en     = pop && !empty;
  assign pop_data   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/node_input_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// node_input_arbiter -- three buffered inputs arbitrated into one output register
// Optional: NODE_ARB_LOCAL_LOWPRI_EN makes local injection strictly lowest priority
// Rev 1.0
// ----------------------------------------------------------------------------
module node_input_arbiter
  import node_pkg::*;
#(
  parameter int                          FIFO_DEPTH = 4,
  parameter logic [NODE_IP_BITWIDTH-1:0] NODE_IP    = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                link0_valid,
  input  logic [INSTR_W-1:0]  link0_data,
  output logic                link0_ready,
  input  logic                link1_valid,
  input  logic [INSTR_W-1:0]  link1_data,
  output logic                link1_ready,
  input  logic                local_valid,
  input  logic [INSTR_W-1:0]  local_data,
  output logic                local_ready,
  output logic                controller_enable,
  output logic [1:0]          source_port,
  output logic [INSTR_W-1:0]  instruction_in,
  input  logic                out_ready
);

  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] in_ready;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_pop;
  logic [INSTR_W-1:0]   in_data   [NUM_PORTS];
  logic [INSTR_W-1:0]   fifo_data [NUM_PORTS];

  logic               out_valid_q, out_valid_d;
  logic [1:0]         src_q, src_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [1:0]         rr_q, rr_d;

  logic               load;
  logic               grant_valid;
  logic [1:0]         grant_port;
  logic [1:0]         cand;
  logic [INSTR_W-1:0] grant_data;
  logic               unused_dbg;

  assign in_valid   = {local_valid, link1_valid, link0_valid};
  assign in_data[0] = link0_data;
  assign in_data[1] = link1_data;
  assign in_data[2] = local_data;

  assign link0_ready = in_ready[0];
  assign link1_ready = in_ready[1];
  assign local_ready = in_ready[2];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_fifo
    node_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INSTR_W)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (in_valid[p]),
      .push_data  (in_data[p]),
      .push_ready (in_ready[p]),
      .pop        (fifo_pop[p]),
      .pop_data   (fifo_data[p]),
      .empty      (fifo_empty[p]),
      .full       (fifo_full[p])
    );
  end

  // Destination-match against this node and FIFO fullness kept for debug probing
  assign unused_dbg = (instr_q[DEST_MSB:DEST_LSB] == NODE_IP) ^ (^fifo_full);

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = PORT_LINK0;
    cand        = rr_q;
`ifdef NODE_ARB_LOCAL_LOWPRI_EN
    for (int i = 0; i < 2; i++) begin
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_port  = cand;
      end
      cand = {1'b0, ~cand[0]};
    end
    if (!grant_valid && !fifo_empty[PORT_LOCAL]) begin
      grant_valid = 1'b1;
      grant_port  = PORT_LOCAL;
    end
`else
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_port  = cand;
      end
      cand = next_port(cand);
    end
`endif
  end

  always_comb begin
    unique case (grant_port)
      PORT_LINK1: grant_data = fifo_data[1];
      PORT_LOCAL: grant_data = fifo_data[2];
      default:    grant_data = fifo_data[0];
    endcase
  end

  // Output register refills when empty or when its word leaves this cycle
  assign load = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    src_d       = src_q;
    instr_d     = instr_q;
    rr_d        = rr_q;
    fifo_pop    = '0;
    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        src_d                = grant_port;
        instr_d              = grant_data;
        fifo_pop[grant_port] = 1'b1;
`ifdef NODE_ARB_LOCAL_LOWPRI_EN
        if (grant_port != PORT_LOCAL) rr_d = {1'b0, ~grant_port[0]};
`else
        rr_d = next_port(grant_port);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      src_q       <= PORT_LINK0;
      instr_q     <= '0;
      rr_q        <= PORT_LINK0;
    end else begin
      out_valid_q <= out_valid_d;
      src_q       <= src_d;
      instr_q     <= instr_d;
      rr_q        <= rr_d;
    end
  end

  assign controller_enable = out_valid_q;
  assign source_port       = src_q;
  assign instruction_in    = instr_q;

endmodule
`default_nettype wire
